// File: rtl/ahb_sub_mem_if.sv
// ----------------------------------------------------------------------------
// ahb_sub_mem_if
// AHB-Lite bus bundle between a manager and the ahb_sub_mem subordinate.
//   master modport : drives hsel, haddr, htrans, hwrite, hsize, hburst,
//                    hwdata, hwstrb and the bus-wide hready; receives
//                    hreadyout, hresp, hrdata.
//   slave  modport : the mirror image.
// ----------------------------------------------------------------------------
interface ahb_sub_mem_if #(
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
);
   logic                   hsel;
   logic [ADDRWIDTH-1:0]   haddr;
   logic [1:0]             htrans;
   logic                   hwrite;
   logic [2:0]             hsize;
   logic [2:0]             hburst;
   logic [DATAWIDTH-1:0]   hwdata;
   logic [DATAWIDTH/8-1:0] hwstrb;
   logic                   hready;
   logic                   hreadyout;
   logic                   hresp;
   logic [DATAWIDTH-1:0]   hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sub_mem.sv
// ----------------------------------------------------------------------------
// ahb_sub_mem
// AHB-Lite subordinate memory model. Captures address phases, stores bus
// words with byte strobes, inserts WAITSTATES wait cycles per transfer and
// answers a configurable address window (or oversized hsize) with a
// two-cycle ERROR response.
// Ports:
//   hclk    : clock, all state changes on the rising edge
//   hresetn : asynchronous active-low reset (memory contents are kept)
//   bus     : ahb_sub_mem_if slave modport (address/data/response signals)
// ----------------------------------------------------------------------------
module ahb_sub_mem #(
   parameter int                   ADDRWIDTH  = 32,
   parameter int                   DATAWIDTH  = 32,
   parameter int                   MEMWORDS   = 4096,
   parameter int                   WAITSTATES = 0,
   parameter logic [ADDRWIDTH-1:0] ERRBASE    = 32'hFFFF_F000,
   parameter logic [ADDRWIDTH-1:0] ERRTOP     = 32'hFFFF_FFFF
) (
   input logic          hclk,
   input logic          hresetn,
   ahb_sub_mem_if.slave bus
);
   localparam int         BYTES     = DATAWIDTH / 8;
   localparam int         LANE_BITS = $clog2(BYTES);
   localparam int         IDX_BITS  = $clog2(MEMWORDS);
   localparam logic [3:0] WAIT_LOAD = 4'(WAITSTATES);
   localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t               state_reg, state_next, start_state;
   logic [3:0]           wait_cnt_reg, wait_cnt_next;
   logic [IDX_BITS-1:0]  index_reg;
   logic                 write_reg;
   logic [BYTES-1:0]     strb_reg;
   logic                 err_reg;
   logic [BYTES-1:0]     lane_we;

   logic [DATAWIDTH-1:0] mem [MEMWORDS] = '{default: '0};

   logic                 accept;
   logic                 addr_err;
   logic [IDX_BITS-1:0]  addr_index;
   logic                 unused_hburst;

   assign accept     = bus.hsel & bus.hready & bus.htrans[1];
   assign addr_index = bus.haddr[LANE_BITS +: IDX_BITS];
   // One extra leading zero keeps the window compares meaningful even when the
   // window touches the top or bottom of the address space.
   assign addr_err   = (({1'b0, bus.haddr} >= {1'b0, ERRBASE}) &&
                        ({1'b0, bus.haddr} <= {1'b0, ERRTOP})) ||
                       (bus.hsize > MAX_SIZE);
   assign unused_hburst = ^bus.hburst;

   // Where a freshly captured transfer goes; errors win over wait states.
   always_comb begin
      start_state = ST_DATA;
      if (addr_err)
         start_state = ST_ERR1;
      else if (WAITSTATES != 0)
         start_state = ST_WAIT;
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      bus.hreadyout = 1'b1;
      bus.hresp     = 1'b0;
      bus.hrdata    = '0;
      case (state_reg)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            // Accepting in the last data-phase cycle gives zero-bubble bursts.
            state_next = accept ? start_state : ST_IDLE;
         end
         ST_WAIT: begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
            if (wait_cnt_reg <= 4'd1)
               state_next = ST_DATA;
         end
         ST_ERR1: state_next = ST_ERR2;
         default: state_next = ST_IDLE;
      endcase
      if ((state_next == ST_WAIT) && (state_reg != ST_WAIT))
         wait_cnt_next = WAIT_LOAD;

      case (state_reg)
         ST_WAIT: bus.hreadyout = 1'b0;
         ST_DATA: begin
            if (!err_reg)
               bus.hrdata = mem[index_reg];
         end
         ST_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = 1'b1;
         end
         ST_ERR2: bus.hresp = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
         index_reg    <= '0;
         write_reg    <= 1'b0;
         strb_reg     <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (accept) begin
            index_reg <= addr_index;
            write_reg <= bus.hwrite;
            strb_reg  <= bus.hwstrb;
            err_reg   <= addr_err;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_lane
         assign lane_we[gi] = (state_reg == ST_DATA) && write_reg && !err_reg && strb_reg[gi];
      end
   endgenerate

   // Write commits on the edge that ends DATA, so a back-to-back read of the
   // same word sees the new bytes through the combinational read path.
   always_ff @(posedge hclk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (lane_we[b])
            mem[index_reg][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
      end
   end
endmodule

// File: tb/tb_ahb_sub_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_sub_mem
// Two subordinates share one driven bus: dut_a (16 words, no wait states) and
// dut_b (4096 words, 3 wait states). cur_sel picks the selected one and the
// bus-wide hready follows it. Expected responses come from a word-array model
// and the transfer timing rules (OK = WAITSTATES+1 cycles, ERROR = 2 cycles).
// ----------------------------------------------------------------------------
module tb_ahb_sub_mem;
   localparam int WS_B    = 3;
   localparam int WORDS_B = 4096;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [2:0]  hburst = 3'd0;
   logic [31:0] hwdata = '0;
   logic [3:0]  hwstrb = '0;
   logic        block_ready = 1'b0;
   logic        cur_sel = 1'b0;
   logic        hready_bus;

   always #5 hclk = ~hclk;

   ahb_sub_mem_if bus_a ();
   ahb_sub_mem_if bus_b ();

   assign hready_bus = block_ready ? 1'b0 : (cur_sel ? bus_b.hreadyout : bus_a.hreadyout);

   assign bus_a.hsel   = hsel & ~cur_sel;
   assign bus_a.haddr  = haddr;
   assign bus_a.htrans = htrans;
   assign bus_a.hwrite = hwrite;
   assign bus_a.hsize  = hsize;
   assign bus_a.hburst = hburst;
   assign bus_a.hwdata = hwdata;
   assign bus_a.hwstrb = hwstrb;
   assign bus_a.hready = hready_bus;

   assign bus_b.hsel   = hsel & cur_sel;
   assign bus_b.haddr  = haddr;
   assign bus_b.htrans = htrans;
   assign bus_b.hwrite = hwrite;
   assign bus_b.hsize  = hsize;
   assign bus_b.hburst = hburst;
   assign bus_b.hwdata = hwdata;
   assign bus_b.hwstrb = hwstrb;
   assign bus_b.hready = hready_bus;

   ahb_sub_mem #(.MEMWORDS(16), .WAITSTATES(0)) dut_a (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus_a)
   );

   ahb_sub_mem #(.MEMWORDS(WORDS_B), .WAITSTATES(WS_B)) dut_b (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus_b)
   );

   typedef struct {
      bit          wr;
      bit          seq;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  size;
   } xfer_t;

   xfer_t       seq_q[$];
   logic [31:0] model_mem [2][WORDS_B];
   int          checks = 0;
   int          errors = 0;
   int          last_total;
   int          low_cnt;
   logic [31:0] last_rd;

   function automatic int unsigned idx(input bit s, input logic [31:0] a);
      return s ? int'(a[13:2]) : int'(a[5:2]);
   endfunction

   function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
      return (a >= 32'hFFFF_F000) || (sz > 3'd2);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_xfer(input bit wr, input bit sq, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] st, input logic [2:0] sz);
      xfer_t x;
      x.wr = wr; x.seq = sq; x.addr = a; x.data = d; x.strb = st; x.size = sz;
      seq_q.push_back(x);
   endtask

   task automatic model_write(input bit s, input xfer_t x);
      for (int b = 0; b < 4; b++)
         if (x.strb[b]) model_mem[s][idx(s, x.addr)][b*8 +: 8] = x.data[b*8 +: 8];
   endtask

   task automatic drive_addr(input xfer_t x);
      hsel   = 1'b1;
      htrans = x.seq ? 2'b11 : 2'b10;
      haddr  = x.addr;
      hwrite = x.wr;
      hwstrb = x.strb;
      hsize  = x.size;
      hburst = 3'b001;
   endtask

   task automatic drive_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hwstrb = '0;
      hsize  = 3'd2;
   endtask

   // Pipelined driver: next address phase is presented while the previous
   // transfer is in its data phase; advances only on edges where hready=1.
   task automatic run_seq(input bit s);
      int n, ai, di, c, exp_c;
      bit rdy, done, e;
      logic rsp;
      logic [31:0] rd;
      xfer_t x;
      n = seq_q.size(); ai = 0; di = -1; c = 0;
      done = (n == 0); last_total = 0; low_cnt = 0;
      cur_sel = s;
      if (n > 0) drive_addr(seq_q[0]);
      while (!done) begin
         @(negedge hclk);
         rdy = s ? bus_b.hreadyout : bus_a.hreadyout;
         rsp = s ? bus_b.hresp : bus_a.hresp;
         rd  = s ? bus_b.hrdata : bus_a.hrdata;
         if (di < 0) begin
            check("idle_ready", rdy, 1);
            check("idle_resp", rsp, 0);
            check("idle_rdata", rd, 0);
         end else begin
            x = seq_q[di];
            e = is_err(x.addr, x.size);
            c++; last_total++;
            if (!rdy) low_cnt++;
            exp_c = e ? 2 : (s ? WS_B + 1 : 1);
            check(x.wr ? "wr_ready" : "rd_ready", rdy, c >= exp_c);
            check("resp", rsp, e);
            if (!rdy)
               check("wait_rdata", rd, 0);
            else if (!x.wr) begin
               check(e ? "err_rdata" : "rd_data", rd, e ? 32'd0 : model_mem[s][idx(s, x.addr)]);
               last_rd = rd;
            end
            if (rdy) begin
               if (x.wr && !e) model_write(s, x);
               $display("xfer dut=%0d %s addr=%08h data=%08h strb=%b resp=%0d cycles=%0d",
                        s, x.wr ? "WR" : "RD", x.addr, x.wr ? x.data : rd, x.strb, rsp, c);
            end
            if (c > 40) begin
               check("timeout_cycles", c, exp_c);
               done = 1;
            end
         end
         if (!done) begin
            @(posedge hclk); #1;
            if (rdy) begin
               if (ai < n) begin
                  di = ai; c = 0;
                  hwdata = seq_q[ai].data;
                  ai++;
                  if (ai < n) drive_addr(seq_q[ai]);
                  else drive_idle();
               end else begin
                  done = 1;
               end
            end
         end
      end
      drive_idle();
      seq_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      xfer_t wx;
      int len;
      bit s;
      logic [31:0] a;
      logic [2:0] sz;

      for (int i = 0; i < 2; i++)
         for (int j = 0; j < WORDS_B; j++) model_mem[i][j] = '0;

      // Reset state
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      check("rst_a_ready", bus_a.hreadyout, 1);
      check("rst_a_resp", bus_a.hresp, 0);
      check("rst_a_rdata", bus_a.hrdata, 0);
      check("rst_b_ready", bus_b.hreadyout, 1);
      check("rst_b_resp", bus_b.hresp, 0);
      @(posedge hclk); #1 hresetn = 1'b1;
      @(posedge hclk); #1;

      // Write then read, zero wait states
      add_xfer(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 3'd2);
      add_xfer(0, 0, 32'h100, 32'h0, 4'h0, 3'd2);
      run_seq(0);
      check("t1_rd", last_rd, 32'hDEADBEEF);
      check("t1_no_wait", low_cnt, 0);

      // Byte strobes
      add_xfer(1, 0, 32'h200, 32'h11223344, 4'hF, 3'd2);
      add_xfer(1, 0, 32'h200, 32'hAABBCCDD, 4'b0101, 3'd2);
      add_xfer(0, 0, 32'h200, 32'h0, 4'h0, 3'd2);
      run_seq(0);
      check("t2_strb_rd", last_rd, 32'h11BB33DD);

      // 4-beat INCR read burst with 3 wait states
      for (int k = 0; k < 4; k++)
         add_xfer(1, k > 0, 32'h300 + 32'(k * 4), 32'hA0A0_0000 + 32'(k), 4'hF, 3'd2);
      run_seq(1);
      for (int k = 0; k < 4; k++)
         add_xfer(0, k > 0, 32'h300 + 32'(k * 4), 32'h0, 4'h0, 3'd2);
      run_seq(1);
      check("t3_burst_cycles", last_total, 16);
      check("t3_burst_low", low_cnt, 12);
      check("t3_last_beat", last_rd, 32'hA0A0_0003);

      // Error window: read error, recovery, errored write leaves memory alone
      add_xfer(1, 0, 32'h4, 32'h13579BDF, 4'hF, 3'd2);
      add_xfer(0, 0, 32'hFFFF_F004, 32'h0, 4'h0, 3'd2);
      add_xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'd2);
      add_xfer(1, 0, 32'hFFFF_F004, 32'hFFFFFFFF, 4'hF, 3'd2);
      add_xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'd2);
      run_seq(0);
      check("t4_after_errwr", last_rd, 32'h13579BDF);

      // Index wrap (16 words): word 15 then SEQ to 0x40 lands on word 0
      add_xfer(1, 0, 32'h3C, 32'h0F0F0F0F, 4'hF, 3'd2);
      add_xfer(0, 1, 32'h40, 32'h0, 4'h0, 3'd2);
      run_seq(0);
      check("t5_wrap_rd", last_rd, 32'h11BB33DD);
      add_xfer(1, 0, 32'h8, 32'h5A5A1234, 4'hF, 3'd2);
      add_xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'd2);
      run_seq(0);
      check("t5_raw_rd", last_rd, 32'h5A5A1234);

      // hready held low by another subordinate blocks capture
      cur_sel = 1'b1;
      block_ready = 1'b1;
      wx.wr = 1; wx.seq = 0; wx.addr = 32'h300; wx.data = 32'hFFFFFFFF; wx.strb = 4'hF; wx.size = 3'd2;
      drive_addr(wx);
      hwdata = 32'hFFFFFFFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge hclk);
         check("t6_blocked_ready", bus_b.hreadyout, 1);
         @(posedge hclk); #1;
      end
      drive_idle();
      block_ready = 1'b0;
      add_xfer(0, 0, 32'h300, 32'h0, 4'h0, 3'd2);
      run_seq(1);
      check("t6_unchanged", last_rd, 32'hA0A0_0000);

      // Reset in the middle of a write's wait states
      add_xfer(1, 0, 32'h500, 32'hCAFEF00D, 4'hF, 3'd2);
      run_seq(1);
      wx.addr = 32'h500; wx.data = 32'h12345678;
      drive_addr(wx);
      @(posedge hclk); #1;
      drive_idle();
      hwdata = 32'h12345678;
      @(negedge hclk);
      check("t7_in_wait", bus_b.hreadyout, 0);
      @(posedge hclk); #1 hresetn = 1'b0;
      #1;
      check("t7_rst_ready", bus_b.hreadyout, 1);
      check("t7_rst_resp", bus_b.hresp, 0);
      @(posedge hclk); #1 hresetn = 1'b1;
      add_xfer(0, 0, 32'h500, 32'h0, 4'h0, 3'd2);
      run_seq(1);
      check("t7_kept_old", last_rd, 32'hCAFEF00D);

      // Randomized sequences against the model
      for (int it = 0; it < 12; it++) begin
         s = it[0];
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            if ($urandom % 8 == 0)
               a = 32'hFFFF_F000 + 32'(($urandom % 1024) * 4);
            else if (s)
               a = 32'h1000 + 32'(($urandom % 16) * 4);
            else
               a = $urandom & 32'h7FFF_FFFC;
            sz = ($urandom % 10 == 0) ? 3'($urandom_range(3, 7)) : 3'd2;
            add_xfer(1'($urandom % 2), (k > 0) && ($urandom % 2 == 1), a, $urandom, 4'($urandom), sz);
         end
         run_seq(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
